// File: rtl/pc_sequencer_if.sv
// Control bus between the jump-decision stage and the PC sequencer.
// The master drives the control inputs; the sequencer (slave) returns the
// PC and the phase indicators.
interface pc_sequencer_if #(
  parameter int PC_WIDTH = 8
);
  logic                en_pc;
  logic [PC_WIDTH-1:0] jump_addr;
  logic                stall;
  logic                halt;
  logic [PC_WIDTH-1:0] pc;
  logic                fetch;
  logic                decode;
  logic                execute;
  logic                increment;
  logic                halted;

  modport master (
    output en_pc, jump_addr, stall, halt,
    input  pc, fetch, decode, execute, increment, halted
  );

  modport slave (
    input  en_pc, jump_addr, stall, halt,
    output pc, fetch, decode, execute, increment, halted
  );
endinterface

// File: rtl/pc_sequencer.sv
// Instruction-phase sequencer with program counter.
// It steps FETCH -> DECODE -> EXECUTE -> INCREMENT and can divert to an
// absorbing HALT state from DECODE. A jump target is loaded in EXECUTE and
// the PC is incremented in INCREMENT, both only when en_pc is high.
// stall freezes everything. The phase outputs are taken directly from a
// one-hot state register, so they are registered and change together with
// the state.
module pc_sequencer #(
  parameter int                  PC_WIDTH     = 8,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
  input logic            clock,
  input logic            clear,
  pc_sequencer_if.slave  bus
);

  // The one-hot encoding lets each phase output be a plain state flop.
  typedef enum logic [4:0] {
    S_FETCH     = 5'b00001,
    S_DECODE    = 5'b00010,
    S_EXECUTE   = 5'b00100,
    S_INCREMENT = 5'b01000,
    S_HALT      = 5'b10000
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] w_pc_inc;

  // The increment wraps naturally modulo 2^PC_WIDTH.
  assign w_pc_inc = r_pc + {{(PC_WIDTH-1){1'b0}}, 1'b1};

  // State register. A low clear forces FETCH at once.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  // Next-state logic. A stall holds the state and takes priority over halt.
  // Illegal encodings recover to FETCH.
  always_comb begin
    w_next = r_state;
    if (!bus.stall) begin
      unique case (r_state)
        S_FETCH:     w_next = S_DECODE;
        S_DECODE:    w_next = bus.halt ? S_HALT : S_EXECUTE;
        S_EXECUTE:   w_next = S_INCREMENT;
        S_INCREMENT: w_next = S_FETCH;
        S_HALT:      w_next = S_HALT;
        default:     w_next = S_FETCH;
      endcase
    end
  end

  // PC register. The jump load happens in EXECUTE and the increment in
  // INCREMENT, each gated by en_pc. A stall blocks both. A clear in the
  // middle of a cycle discards any update that was pending.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_pc <= RESET_VECTOR;
    end else if (!bus.stall && bus.en_pc) begin
      if (r_state == S_EXECUTE)        r_pc <= bus.jump_addr;
      else if (r_state == S_INCREMENT) r_pc <= w_pc_inc;
    end
  end

  assign bus.pc        = r_pc;
  assign bus.fetch     = r_state[0];
  assign bus.decode    = r_state[1];
  assign bus.execute   = r_state[2];
  assign bus.increment = r_state[3];
  assign bus.halted    = r_state[4];

endmodule
